// File: rtl/planificador_ascensor.sv
// ---------------------------------------------------------------------------
// planificador_ascensor
// SCAN scheduler for a single-car, 4-floor elevator. It latches hall and car
// calls, picks the travel direction, drives the motor, and hands each stop to
// the door controller. It waits for the door controller's busy flag to rise
// and then fall before the car moves again.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   botones      call presses (level or pulse):
//                  [0] F1 up, [1] F2 down, [2] F2 up,
//                  [3] F3 down, [4] F3 up, [5] F4 down,
//                  [9:6] car calls F1..F4
//   llegada      one-cycle pulse: the car reached the next floor
//   trabajando   door controller busy
//   pendientes   registered pending calls (same encoding as botones)
//   estado       [1:0] floor, [2] direction (1 = up), [3] moving
//   motor        01 up, 10 down, 00 stop
//   error_puerta sticky door-handshake timeout flag
//
// ANCHO_CNT must satisfy 2**ANCHO_CNT > ESPERA_MAX, and ESPERA_MAX >= 1.
// ---------------------------------------------------------------------------
module planificador_ascensor #(
    parameter int ESPERA_MAX = 255,
    parameter int ANCHO_CNT  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] botones,
    input  logic       llegada,
    input  logic       trabajando,
    output logic [9:0] pendientes,
    output logic [3:0] estado,
    output logic [1:0] motor,
    output logic       error_puerta
);

    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        MOVER      = 2'd1,
        SERVIR_INI = 2'd2,
        SERVIR_FIN = 2'd3
    } fsm_t;

    fsm_t                 est_q, est_d;
    logic [1:0]           piso_q, piso_d;
    logic                 dir_q, dir_d;
    logic [1:0]           motor_q, motor_d;
    logic [ANCHO_CNT-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [9:0]           pend_q, pend_d;
    logic [9:0]           borrar;

    // Mask of the floors strictly beyond f in the given direction.
    function automatic logic [3:0] mascara_mas_alla(input logic [1:0] f, input logic sube);
        logic [3:0] arriba, abajo;
        arriba = 4'b1110 << f;
        abajo  = 4'b0111 >> (2'd3 - f);
        return sube ? arriba : abajo;
    endfunction

    // Bits released when floor f is served heading in direction sube. At the
    // terminal floors there is only one hall button, and it is always cleared.
    function automatic logic [9:0] mascara_servicio(input logic [1:0] f, input logic sube);
        logic [9:0] m;
        case (f)
            2'd0:    m = 10'h041;
            2'd1:    m = 10'h080 | (sube ? 10'h004 : 10'h002);
            2'd2:    m = 10'h100 | (sube ? 10'h010 : 10'h008);
            default: m = 10'h220;
        endcase
        return m;
    endfunction

    // Per-floor views of the pending calls. There is no up button at F4 and no
    // down button at F1.
    logic [3:0] cab, sub, baj, llamada;
    assign cab     = pend_q[9:6];
    assign sub     = {1'b0, pend_q[4], pend_q[2], pend_q[0]};
    assign baj     = {pend_q[5], pend_q[3], pend_q[1], 1'b0};
    assign llamada = cab | sub | baj;

    // Decisions taken at the current floor (used in REPOSO).
    logic adelante, atras, aqui_d, aqui_o;
    assign adelante = |(llamada & mascara_mas_alla(piso_q, dir_q));
    assign atras    = |(llamada & mascara_mas_alla(piso_q, ~dir_q));
    assign aqui_d   = cab[piso_q] | (dir_q ? sub[piso_q] : baj[piso_q]);
    assign aqui_o   = dir_q ? baj[piso_q] : sub[piso_q];

    // Decisions taken at the floor being reached (used in MOVER on llegada).
    // The floor index saturates instead of wrapping.
    logic [1:0] piso_sig;
    logic       para_d, para_o, terminal;
    assign piso_sig = dir_q ? ((piso_q == 2'd3) ? 2'd3 : piso_q + 2'd1)
                            : ((piso_q == 2'd0) ? 2'd0 : piso_q - 2'd1);
    assign para_d   = cab[piso_sig] | (dir_q ? sub[piso_sig] : baj[piso_sig]);
    // An opposite hall call is only taken when nothing waits further ahead;
    // otherwise it is picked up on the way back.
    assign para_o   = (dir_q ? baj[piso_sig] : sub[piso_sig])
                    & ~|(llamada & mascara_mas_alla(piso_sig, dir_q));
    assign terminal = (piso_sig == 2'd0) || (piso_sig == 2'd3);

    // Timeout fires on the ESPERA_MAX-th cycle spent in SERVIR_INI.
    logic       agotado;
    logic [9:0] servicio;
    assign agotado  = (cnt_q == ANCHO_CNT'(ESPERA_MAX - 1));
    assign servicio = mascara_servicio(piso_q, dir_q);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) est_q <= REPOSO;
        else        est_q <= est_d;
    end

    // ---------------- next state ----------------
    always_comb begin
        est_d = est_q;
        case (est_q)
            REPOSO: begin
                if (aqui_d || (!adelante && aqui_o)) est_d = SERVIR_INI;
                else if (adelante || atras)          est_d = MOVER;
            end
            MOVER: begin
                if (llegada) begin
                    if (para_d || para_o) est_d = SERVIR_INI;
                    else if (terminal)    est_d = REPOSO;
                end
            end
            SERVIR_INI: begin
                if (trabajando)   est_d = SERVIR_FIN;
                else if (agotado) est_d = REPOSO;
            end
            SERVIR_FIN: begin
                if (!trabajando) est_d = REPOSO;
            end
            default: est_d = REPOSO;
        endcase
    end

    // ---------------- outputs / datapath next values ----------------
    always_comb begin
        piso_d  = piso_q;
        dir_d   = dir_q;
        motor_d = motor_q;
        cnt_d   = '0;
        err_d   = err_q;
        borrar  = '0;
        case (est_q)
            REPOSO: begin
                if (aqui_d) begin
                    motor_d = 2'b00;
                end else if (adelante) begin
                    motor_d = dir_q ? 2'b01 : 2'b10;
                end else if (aqui_o) begin
                    dir_d = ~dir_q;
                end else if (atras) begin
                    dir_d   = ~dir_q;
                    motor_d = dir_q ? 2'b10 : 2'b01;
                end
            end
            MOVER: begin
                if (llegada) begin
                    piso_d = piso_sig;
                    if (para_d) begin
                        motor_d = 2'b00;
                    end else if (para_o) begin
                        dir_d   = ~dir_q;
                        motor_d = 2'b00;
                    end else if (terminal) begin
                        motor_d = 2'b00;
                    end
                end
            end
            SERVIR_INI: begin
                if (trabajando) begin
                    borrar = servicio;
                end else if (agotado) begin
                    err_d  = 1'b1;
                    borrar = servicio;
                end else begin
                    cnt_d = cnt_q + ANCHO_CNT'(1);
                end
            end
            default: ;
        endcase
        // A press on a bit being served this edge is dropped: the doors are open.
        pend_d = (pend_q | botones) & ~borrar;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            piso_q  <= 2'd0;
            dir_q   <= 1'b1;
            motor_q <= 2'b00;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            piso_q  <= piso_d;
            dir_q   <= dir_d;
            motor_q <= motor_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end

    assign pendientes   = pend_q;
    assign motor        = motor_q;
    assign estado       = {(motor_q != 2'b00), dir_q, piso_q};
    assign error_puerta = err_q;

endmodule

// File: tb/tb_planificador_ascensor.sv
module tb_planificador_ascensor;

    localparam int ESPERA = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] botones;
    logic       llegada;
    logic       trabajando;
    logic [9:0] pendientes;
    logic [3:0] estado;
    logic [1:0] motor;
    logic       error_puerta;

    int checks = 0;
    int errors = 0;

    planificador_ascensor #(.ESPERA_MAX(ESPERA), .ANCHO_CNT(5)) dut (
        .clk(clk), .rst_n(rst_n), .botones(botones), .llegada(llegada),
        .trabajando(trabajando), .pendientes(pendientes), .estado(estado),
        .motor(motor), .error_puerta(error_puerta)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Modes: 0 idle, 1 moving, 2 waiting for door busy, 3 waiting for door idle.
    int         ms, mf, mmot, mcnt;
    bit         md, merr;
    logic [9:0] mp;

    // Button index for a hall call at floor f in a direction, -1 if none exists.
    function automatic int idx_hall(int f, bit up);
        if (up) return (f == 0) ? 0 : (f == 1) ? 2 : (f == 2) ? 4 : -1;
        else    return (f == 1) ? 1 : (f == 2) ? 3 : (f == 3) ? 5 : -1;
    endfunction

    function automatic bit hay(logic [9:0] p, int i);
        return (i >= 0) ? p[i] : 1'b0;
    endfunction

    function automatic bit piso_con_llamada(logic [9:0] p, int f);
        return hay(p, 6 + f) || hay(p, idx_hall(f, 1'b1)) || hay(p, idx_hall(f, 1'b0));
    endfunction

    function automatic bit mas_alla(logic [9:0] p, int f, bit up);
        for (int j = 0; j < 4; j++)
            if (((up && j > f) || (!up && j < f)) && piso_con_llamada(p, j)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [9:0] atendidos(int f, bit up);
        logic [9:0] m;
        m = '0;
        m[6 + f] = 1'b1;
        if (f == 0 || f == 3) begin
            if (idx_hall(f, 1'b1) >= 0) m[idx_hall(f, 1'b1)] = 1'b1;
            if (idx_hall(f, 1'b0) >= 0) m[idx_hall(f, 1'b0)] = 1'b1;
        end else begin
            m[idx_hall(f, up)] = 1'b1;
        end
        return m;
    endfunction

    task automatic model_reset();
        ms = 0; mf = 0; md = 1'b1; mmot = 0; mcnt = 0; merr = 1'b0; mp = '0;
    endtask

    task automatic model_step();
        logic [9:0] clr;
        int nf;
        clr = '0;
        case (ms)
            0: begin
                if (hay(mp, 6 + mf) || hay(mp, idx_hall(mf, md))) begin
                    ms = 2; mcnt = 0;
                end else if (mas_alla(mp, mf, md)) begin
                    ms = 1; mmot = md ? 1 : 2;
                end else if (hay(mp, idx_hall(mf, !md))) begin
                    md = !md; ms = 2; mcnt = 0;
                end else if (mas_alla(mp, mf, !md)) begin
                    md = !md; ms = 1; mmot = md ? 1 : 2;
                end
            end
            1: if (llegada) begin
                nf = md ? ((mf < 3) ? mf + 1 : 3) : ((mf > 0) ? mf - 1 : 0);
                mf = nf;
                if (hay(mp, 6 + nf) || hay(mp, idx_hall(nf, md))) begin
                    ms = 2; mmot = 0; mcnt = 0;
                end else if (hay(mp, idx_hall(nf, !md)) && !mas_alla(mp, nf, md)) begin
                    md = !md; ms = 2; mmot = 0; mcnt = 0;
                end else if (nf == 0 || nf == 3) begin
                    ms = 0; mmot = 0;
                end
            end
            2: begin
                if (trabajando) begin
                    clr = atendidos(mf, md); ms = 3;
                end else if (mcnt + 1 == ESPERA) begin
                    merr = 1'b1; clr = atendidos(mf, md); ms = 0;
                end else begin
                    mcnt++;
                end
            end
            default: if (!trabajando) ms = 0;
        endcase
        mp = (mp | botones) & ~clr;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(string n);
        logic [3:0] e;
        e = {(mmot != 0), md, 2'(mf)};
        chk({n, "_pend"}, 32'(pendientes), 32'(mp));
        chk({n, "_estado"}, 32'(estado), 32'(e));
        chk({n, "_motor"}, 32'(motor), 32'(mmot));
        chk({n, "_err"}, 32'(error_puerta), 32'(merr));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; botones = '0; llegada = 1'b0; trabajando = 1'b0;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic [9:0] b;
        logic       l;
        logic       t;
        logic [9:0] ep;
        logic [3:0] ee;
        logic [1:0] em;
    } vec_t;

    vec_t tbl[13];
    int   hold;

    initial begin
        // Trip to F4 and back toward F1, cycle by cycle.
        tbl[0]  = '{10'h200, 1'b0, 1'b0, 10'h200, 4'b0100, 2'b00};
        tbl[1]  = '{10'h000, 1'b0, 1'b0, 10'h200, 4'b1100, 2'b01};
        tbl[2]  = '{10'h000, 1'b1, 1'b0, 10'h200, 4'b1101, 2'b01};
        tbl[3]  = '{10'h000, 1'b0, 1'b0, 10'h200, 4'b1101, 2'b01};
        tbl[4]  = '{10'h000, 1'b1, 1'b0, 10'h200, 4'b1110, 2'b01};
        tbl[5]  = '{10'h000, 1'b1, 1'b0, 10'h200, 4'b0111, 2'b00};
        tbl[6]  = '{10'h000, 1'b0, 1'b0, 10'h200, 4'b0111, 2'b00};
        tbl[7]  = '{10'h000, 1'b0, 1'b1, 10'h000, 4'b0111, 2'b00};
        tbl[8]  = '{10'h000, 1'b0, 1'b1, 10'h000, 4'b0111, 2'b00};
        tbl[9]  = '{10'h000, 1'b0, 1'b0, 10'h000, 4'b0111, 2'b00};
        tbl[10] = '{10'h000, 1'b0, 1'b0, 10'h000, 4'b0111, 2'b00};
        tbl[11] = '{10'h040, 1'b0, 1'b0, 10'h040, 4'b0111, 2'b00};
        tbl[12] = '{10'h000, 1'b0, 1'b0, 10'h040, 4'b1011, 2'b10};

        do_reset();
        #1;
        chk("reset_pend", 32'(pendientes), 32'h0);
        chk("reset_estado", 32'(estado), 32'h4);
        chk("reset_motor", 32'(motor), 32'h0);
        chk("reset_err", 32'(error_puerta), 32'h0);

        for (int i = 0; i < 13; i++) begin
            botones = tbl[i].b; llegada = tbl[i].l; trabajando = tbl[i].t;
            tick();
            chk($sformatf("vec%0d_pend", i), 32'(pendientes), 32'(tbl[i].ep));
            chk($sformatf("vec%0d_estado", i), 32'(estado), 32'(tbl[i].ee));
            chk($sformatf("vec%0d_motor", i), 32'(motor), 32'(tbl[i].em));
            chk($sformatf("vec%0d_err", i), 32'(error_puerta), 32'h0);
        end

        // Door timeout, stickiness, and clear on reset.
        do_reset();
        botones = 10'h040; tick();
        botones = '0;      tick();
        repeat (ESPERA - 1) tick();
        chk("to_before_err", 32'(error_puerta), 32'h0);
        chk("to_before_pend", 32'(pendientes), 32'h040);
        tick();
        chk("to_err", 32'(error_puerta), 32'h1);
        chk("to_pend_clr", 32'(pendientes), 32'h0);
        chk("to_motor", 32'(motor), 32'h0);
        repeat (5) tick();
        chk("to_sticky", 32'(error_puerta), 32'h1);
        do_reset();
        #1;
        chk("to_reset_clr", 32'(error_puerta), 32'h0);

        // Press landing on the borrar edge is dropped; a later press re-serves.
        botones = 10'h040; tick();
        botones = '0;      tick();
        chk("sv_estado", 32'(estado), 32'h4);
        botones = 10'h040; trabajando = 1'b1; tick();
        chk("sv_drop", 32'(pendientes), 32'h0);
        botones = 10'h040; tick();
        chk("sv_latch", 32'(pendientes), 32'h040);
        botones = '0; trabajando = 1'b0; tick();
        tick();
        chk("sv_again_motor", 32'(motor), 32'h0);
        chk("sv_again_pend", 32'(pendientes), 32'h040);
        trabajando = 1'b1; tick();
        chk("sv_again_clr", 32'(pendientes), 32'h0);
        trabajando = 1'b0; tick();

        // Asynchronous reset while moving.
        do_reset();
        botones = 10'h200; tick();
        botones = '0;      tick();
        llegada = 1'b1;    tick();
        tick();
        llegada = 1'b0;
        chk("ar_moving", 32'(estado), 32'hE);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ar_motor", 32'(motor), 32'h0);
        chk("ar_estado", 32'(estado), 32'h4);
        chk("ar_pend", 32'(pendientes), 32'h0);

        // Guided scenario: F3 up and F2 down pending at F1, prompt door and motor.
        do_reset();
        botones = 10'h012; tick(); check_model("g2");
        botones = '0;
        hold = 0;
        for (int c = 0; c < 60; c++) begin
            llegada = (ms == 1);
            if (ms == 2) begin trabajando = 1'b1; hold = 2; end
            else if (ms == 3 && hold > 0) begin trabajando = 1'b1; hold--; end
            else trabajando = 1'b0;
            tick(); check_model("g2");
        end

        // Guided scenario: car call F4, then F3 down pressed while climbing.
        do_reset();
        botones = 10'h200; tick(); check_model("g3");
        botones = '0;
        for (int c = 0; c < 60; c++) begin
            botones  = (ms == 1 && mf == 1) ? 10'h008 : 10'h000;
            llegada  = (ms == 1) && (c % 2 == 1);
            trabajando = (ms == 2) || (ms == 3 && c % 3 != 0);
            tick(); check_model("g3");
        end

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            botones = ($urandom_range(0, 5) == 0) ? (10'(1) << $urandom_range(0, 9)) : 10'h000;
            llegada = (ms == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            case (ms)
                2:       trabajando = ($urandom_range(0, 7) == 0);
                3:       trabajando = ($urandom_range(0, 3) != 0);
                default: trabajando = ($urandom_range(0, 15) == 0);
            endcase
            tick(); check_model("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/planificador_ascensor.md
Name: planificador_ascensor

Overview:
Sequential scheduler for the single-car, 4-floor elevator. Latches hall and car calls, runs a SCAN policy (keep direction while calls remain ahead, else reverse) and drives the motor. Publishes the car state and pending calls to the door controller, then waits on the door controller's busy flag before it moves again.

Parameters:
ESPERA_MAX, 255, max cycles in SERVIR_INI waiting for trabajando to rise before a door fault.
ANCHO_CNT, 8, width of the wait counter; must satisfy 2^ANCHO_CNT > ESPERA_MAX.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
botones  input  10  call presses, level or pulse, OR-ed into pendientes. Bit 0: F1 up. Bit 1: F2 down. Bit 2: F2 up. Bit 3: F3 down. Bit 4: F3 up. Bit 5: F4 down. Bits 6-9: car call F1-F4.
llegada  input  1  one-cycle pulse, car has reached the adjacent floor in the motor direction
trabajando  input  1  door controller busy
pendientes  output  10  registered pending calls, same encoding as botones; also lamp drive
estado  output  4  [1:0] floor 0-3, [2] direction (1 = up), [3] moving
motor  output  2  01 up, 10 down, 00 stop
error_puerta  output  1  sticky door-handshake fault

Behaviour:
- Reset (async, rst_n=0):
  - pendientes=0, estado=4'b0100 (F1, up, stopped), motor=00, error_puerta=0.
  - FSM goes to REPOSO and the wait counter clears. This also applies mid-move.
- All outputs are registered. estado[3]=1 exactly when motor!=00.
- Call latch: each edge, pendientes <= (pendientes | botones) & ~borrar.
  - A press on a bit being cleared that same edge is discarded, because the doors are open.
- Definitions: f = current floor, d = direction.
  - adelante = any pending call on a floor strictly beyond f in direction d.
  - atras = any pending call on a floor strictly behind f (opposite direction).
  - aqui_d = car call f, or hall call at f in direction d.
  - aqui_o = hall call at f in the opposite direction.
- REPOSO (motor=00). Priority, top wins:
  1. aqui_d -> SERVIR_INI.
  2. adelante -> MOVER; motor set to d on the next edge.
  3. aqui_o -> flip d, then SERVIR_INI.
  4. atras -> flip d, then MOVER.
  5. Otherwise stay in REPOSO.
  - Latency: a press at edge n is visible at n+1; motor is asserted at n+2.
- MOVER (motor = d ? 01 : 10):
  - On llegada: f <= f+1 (up) or f-1 (down). Evaluate the new floor f' on the same edge.
  - Stop at f' (motor=00, next state SERVIR_INI) if any of:
    - car call f';
    - hall call f' in direction d;
    - hall call f' opposite and no call beyond f'. In this case d flips.
  - If f' is terminal (0 or 3) and none of the above holds, stop into REPOSO.
  - Otherwise keep moving.
  - llegada outside MOVER is ignored. f never wraps; it saturates at 0 and 3.
- SERVIR_INI (motor=00):
  - Count cycles while waiting for trabajando=1.
  - When trabajando=1: assert borrar for car call f and hall call f in direction d (at a terminal floor, both hall bits of that floor). Go to SERVIR_FIN.
  - When the count reaches ESPERA_MAX: set error_puerta, clear the same bits, go to REPOSO.
- SERVIR_FIN: wait for trabajando=0, then go to REPOSO. No timeout; the door controller owns the door timeout.
- While in SERVIR_*, botones is still latched, except the served-floor bits cleared on the borrar edge.
- error_puerta clears only on reset.

Test Plan:
1. Reset at F1; pulse botones[9] (car F4) -> pendientes[9]=1 next edge; motor=01 one edge later. After 3 llegada pulses, estado=4'b0111 and motor=00. Raise trabajando, then drop it -> pendientes[9]=0; FSM back in REPOSO.
2. At F1, pend bits 4 (F3 up) and 1 (F2 down) -> car passes F2 without stopping and stops at F3 with d=up. After service, d flips; the car goes down and stops at F2.
3. Moving up F2->F3, press bit 3 (F3 down) with a pending car call F4 -> no stop at F3. Stop at F4, then serve F3 going down.
4. At SERVIR_INI, hold trabajando=0 for ESPERA_MAX cycles -> error_puerta=1, served bits cleared, REPOSO. Sticky until rst_n pulse.
5. Press bit 6 (car F1) on the same edge trabajando rises at F1 -> bit stays 0. Press bit 6 during SERVIR_FIN -> bit latches, and the car re-serves F1 from REPOSO.
6. Assert rst_n=0 mid-MOVER at F2 -> motor=00, estado=4'b0100, pendientes=0 immediately, with no clock edge required.
